hh_event_arbiter: RTL

- Co-simulation-side scheduler that watches N_SIG DUT signals, detects value changes and serialises them as timestamped events over a single valid/ready channel to the DPI read pump.
- One event is consumed per handshake.
- Channels are shared round-robin so no signal starves.
- Sits between the DUT boundary signals and the framework's per-signal read call; replaces one watcher process per signal.

---
 rtl/hh_event_arbiter_if.sv | 34 +++
 rtl/hh_event_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/hh_event_arbiter_if.sv
// -----------------------------------------------------------------------------
// hh_event_arbiter_if
//   Event channel between hh_event_arbiter and the read pump.
//   One event is transferred on every clock where ev_valid && ev_ready.
//
//   Signals:
//     ev_valid  event available (source -> sink)
//     ev_ready  sink accepts the event (sink -> source)
//     ev_id     id of the reporting channel
//     ev_val    4-state code of the new value (0=0, 1=1, 2=X, 3=Z)
//     ev_time   timestamp of the change
//
//   Modports: master = event source (the arbiter), slave = event sink.
// -----------------------------------------------------------------------------
interface hh_event_arbiter_if #(
    parameter int ID_W = 8,
    parameter int TS_W = 32
);
    logic            ev_valid;
    logic            ev_ready;
    logic [ID_W-1:0] ev_id;
    logic [1:0]      ev_val;
    logic [TS_W-1:0] ev_time;

    modport master (
        output ev_valid, ev_id, ev_val, ev_time,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_id, ev_val, ev_time,
        output ev_ready
    );
endinterface

// File: rtl/hh_event_arbiter.sv
// -----------------------------------------------------------------------------
// hh_event_arbiter
//   Watches N_SIG 4-state signal codes, detects value changes while running and
//   serialises them as timestamped events over one valid/ready channel. Each
//   channel owns a single pending slot; slots are granted round-robin to the
//   output register so no channel starves.
//
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     en          capture enable; rising edge arms the channels (IDLE->ARM->RUN)
//     sig_code    per-channel code, channel i at [2i+1:2i]
//     ev          event channel (hh_event_arbiter_if.master)
//     ovf         sticky per-channel lost-event flags
//     ovf_clr     clears all ovf bits (wins over a same-edge set)
//     busy        a pending slot or the output register is occupied
//     ts_sat      (HH_EV_TS_SAT_EN only) timestamp reached its maximum
//
//   Build option:
//     HH_EV_TS_SAT_EN  timestamp saturates at 2^TS_W-1 instead of wrapping and
//                      the ts_sat port is added.
// -----------------------------------------------------------------------------
module hh_event_arbiter #(
    parameter int N_SIG   = 6,
    parameter int ID_BASE = 1,
    parameter int ID_W    = 8,
    parameter int TS_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [2*N_SIG-1:0]   sig_code,
    hh_event_arbiter_if.master   ev,
    output logic [N_SIG-1:0]     ovf,
    input  logic                 ovf_clr,
`ifdef HH_EV_TS_SAT_EN
    output logic                 ts_sat,
`endif
    output logic                 busy
);
    localparam int IDX_W = (N_SIG > 1) ? $clog2(N_SIG) : 1;
    localparam logic [TS_W-1:0] TS_MAX = '1;

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    state_t           state;
    logic [TS_W-1:0]  ts;
    logic [IDX_W-1:0] rr;

    logic [1:0]       prev     [N_SIG];
    logic [N_SIG-1:0] pend_v;
    logic [1:0]       pend_code[N_SIG];
    logic [TS_W-1:0]  pend_ts  [N_SIG];

    logic [N_SIG-1:0] chg;
    logic [N_SIG-1:0] ovf_set;
    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx;
    logic             take;
    logic             grant_fire;
    int               scan_idx;

    // The output register may load when it is empty or being handed over.
    assign take       = !ev.ev_valid || ev.ev_ready;
    assign grant_fire = take && grant_vld;
    assign busy       = ev.ev_valid | (|pend_v);

    // NOTE: every variable written here gets a value before any condition,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        chg       = '0;
        ovf_set   = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        // First pending slot at or after rr, scanning upward with wrap.
        for (int k = 0; k < N_SIG; k++) begin
            scan_idx = int'(rr) + k;
            if (scan_idx >= N_SIG) scan_idx = scan_idx - N_SIG;
            if (!grant_vld && pend_v[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(scan_idx);
            end
        end
        for (int i = 0; i < N_SIG; i++) begin
            chg[i] = (state == RUN) && (sig_code[2*i +: 2] != prev[i]);
            // A change landing on the edge its own slot is granted simply
            // reloads the slot, so nothing is lost.
            ovf_set[i] = chg[i] && pend_v[i] &&
                         !(grant_fire && (int'(grant_idx) == i));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ts          <= '0;
            rr          <= '0;
            pend_v      <= '0;
            ovf         <= '0;
            ev.ev_valid <= 1'b0;
            ev.ev_id    <= '0;
            ev.ev_val   <= '0;
            ev.ev_time  <= '0;
`ifdef HH_EV_TS_SAT_EN
            ts_sat      <= 1'b0;
`endif
            // NOTE: these arrays are a handful of flops, not a RAM, so they
            // are reset explicitly to give deterministic prev/slot contents.
            for (int i = 0; i < N_SIG; i++) begin
                prev[i]      <= '0;
                pend_code[i] <= '0;
                pend_ts[i]   <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (en) state <= ARM;
                end
                ARM: begin
                    for (int i = 0; i < N_SIG; i++) prev[i] <= sig_code[2*i +: 2];
                    ts    <= '0;
                    state <= RUN;
`ifdef HH_EV_TS_SAT_EN
                    ts_sat <= 1'b0;
`endif
                end
                RUN: begin
`ifdef HH_EV_TS_SAT_EN
                    if (ts != TS_MAX) begin
                        ts <= ts + TS_W'(1);
                        if (ts == TS_MAX - TS_W'(1)) ts_sat <= 1'b1;
                    end
`else
                    ts <= ts + TS_W'(1);
`endif
                    if (!en) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            for (int i = 0; i < N_SIG; i++) begin
                if (chg[i]) begin
                    prev[i]      <= sig_code[2*i +: 2];
                    pend_v[i]    <= 1'b1;
                    pend_code[i] <= sig_code[2*i +: 2];
                    pend_ts[i]   <= ts;
                end else if (grant_fire && (int'(grant_idx) == i)) begin
                    pend_v[i] <= 1'b0;
                end
            end

            if (ovf_clr) ovf <= '0;
            else         ovf <= ovf | ovf_set;

            if (take) begin
                ev.ev_valid <= grant_vld;
                if (grant_vld) begin
                    ev.ev_id   <= ID_W'(ID_BASE) + ID_W'(grant_idx);
                    ev.ev_val  <= pend_code[grant_idx];
                    ev.ev_time <= pend_ts[grant_idx];
                    rr <= (int'(grant_idx) == N_SIG - 1) ? '0 : grant_idx + IDX_W'(1);
                end
            end
        end
    end
endmodule
